g_logic_pipe: RTL and testbench

//  Parametrised, pipelined bitwise logic unit for the gate-level ALU. It computes one of

---
 rtl/g_logic_pipe.sv | 139 +++++++++++++
 tb/tb_g_logic_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/g_logic_pipe.sv
// g_logic_pipe: pipelined bitwise logic unit for the gate-level ALU.
// Results go through a 2-entry FIFO with valid/ready on both sides.
module g_logic_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [2:0]       Op,
    input  logic             Enable,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Parity,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [CNT_W-1:0] OpCount
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             par;
    } ent_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    ent_t             head_q, head_d;
    ent_t             tail_q, tail_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] f_res;
    ent_t             new_ent;
    logic             accept;
    logic             pop;

    // Logic function, enable gating and per-entry flags
    always_comb begin
        f_res = '0;
        case (Op)
            3'b000:  f_res = In1 & In2;
            3'b001:  f_res = In1 | In2;
            3'b010:  f_res = In1 ^ In2;
            3'b011:  f_res = ~(In1 | In2);
            3'b100:  f_res = ~(In1 & In2);
            3'b101:  f_res = ~(In1 ^ In2);
            3'b110:  f_res = In1 & ~In2;
            default: f_res = In1;
        endcase
        new_ent.data = Enable ? f_res : '0;
        new_ent.zero = ~|new_ent.data;
        new_ent.par  = ^new_ent.data;
    end

    assign accept = InValid & in_ready_q;
    assign pop    = (state_q != EMPTY) & OutReady;

    // Queue occupancy FSM; ready is registered from next occupancy
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) state_d = ONE;
            end
            ONE: begin
                if (accept && !pop)      state_d = FULL;
                else if (pop && !accept) state_d = EMPTY;
            end
            FULL: begin
                if (pop) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d = (state_d != FULL);
    end

    // Entry storage; head is kept on drain so outputs hold last value
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) head_d = new_ent;
            end
            ONE: begin
                if (accept && pop) head_d = new_ent;
                else if (accept)   tail_d = new_ent;
            end
            FULL: begin
                if (pop) head_d = tail_q;
            end
            default: begin
                head_d = head_q;
            end
        endcase
    end

    // Saturating count of accepted operations
    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = (state_q != EMPTY);
    assign Out      = head_q.data;
    assign Zero     = head_q.zero;
    assign Parity   = head_q.par;
    assign OpCount  = cnt_q;

endmodule

// File: tb/tb_g_logic_pipe.sv
// tb_g_logic_pipe: directed vectors for g_logic_pipe.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_g_logic_pipe;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] In1, In2;
    logic [2:0]  Op;
    logic        Enable, InValid, OutReady;

    logic        rdy_a, ov_a, z_a, p_a;
    logic [31:0] out_a;
    logic [15:0] cnt_a;

    logic        rdy_b, ov_b, z_b, p_b;
    logic [31:0] out_b;
    logic [1:0]  cnt_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    g_logic_pipe #(.WIDTH(32), .CNT_W(16)) dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .In1(In1), .In2(In2), .Op(Op),
        .Enable(Enable), .InValid(InValid), .InReady(rdy_a),
        .Out(out_a), .Zero(z_a), .Parity(p_a), .OutValid(ov_a),
        .OutReady(OutReady), .OpCount(cnt_a)
    );

    g_logic_pipe #(.WIDTH(32), .CNT_W(2)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .In1(In1), .In2(In2), .Op(Op),
        .Enable(Enable), .InValid(InValid), .InReady(rdy_b),
        .Out(out_b), .Zero(z_b), .Parity(p_b), .OutValid(ov_b),
        .OutReady(OutReady), .OpCount(cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst_n   = 1'b0;
        InValid = 1'b0;
        tick();
        Rst_n = 1'b1;
        tick();
    endtask

    logic [31:0] exp_ops [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_ops[0] = 32'h00F0_000F;
        exp_ops[1] = 32'hFFF0_0FFF;
        exp_ops[2] = 32'hFF00_0FF0;
        exp_ops[3] = 32'h000F_F000;
        exp_ops[4] = 32'hFF0F_FFF0;
        exp_ops[5] = 32'h00FF_F00F;
        exp_ops[6] = 32'hF000_00F0;
        exp_ops[7] = 32'hF0F0_00FF;

        Rst_n    = 1'b0;
        In1      = 32'hDEAD_BEEF;
        In2      = 32'h1234_5678;
        Op       = 3'd1;
        Enable   = 1'b1;
        InValid  = 1'b1;
        OutReady = 1'b1;

        // 1: reset held with InValid=1
        repeat (3) tick();
        check("rst_ov", ov_a, 0);
        check("rst_rdy", rdy_a, 0);
        check("rst_cnt", cnt_a, 0);
        check("rst_out", out_a, 0);
        check("rst_zp", {z_a, p_a}, 0);
        InValid = 1'b0;
        Rst_n   = 1'b1;
        tick();
        check("rel_rdy", rdy_a, 1);
        check("rel_ov", ov_a, 0);

        // 2: all eight ops back to back
        In1     = 32'hF0F0_00FF;
        In2     = 32'h0FF0_0F0F;
        InValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Op = 3'(i);
            tick();
            check($sformatf("op%0d_out", i), out_a, exp_ops[i]);
            check($sformatf("op%0d_ov", i), ov_a, 1);
        end
        check("ops_cnt", cnt_a, 8);
        InValid = 1'b0;
        tick();
        check("drain_ov", ov_a, 0);
        check("drain_hold", out_a, 32'hF0F0_00FF);

        // 3: enable gating and flags
        InValid = 1'b1;
        Op      = 3'b010;
        In1     = 32'hFFFF_FFFF;
        In2     = 32'h0;
        Enable  = 1'b0;
        tick();
        check("en0_out", out_a, 0);
        check("en0_zp", {z_a, p_a}, 2'b10);
        Enable = 1'b1;
        tick();
        check("en1_out", out_a, 32'hFFFF_FFFF);
        check("en1_zp", {z_a, p_a}, 2'b00);
        In1 = 32'h1;
        tick();
        check("par1_zp", {z_a, p_a}, 2'b01);
        InValid = 1'b0;
        tick();

        // 4: backpressure
        do_reset();
        OutReady = 1'b0;
        InValid  = 1'b1;
        Op       = 3'b111;
        In1      = 32'hAAAA_0001;
        tick();
        check("bp_a_rdy", rdy_a, 1);
        In1 = 32'hBBBB_0002;
        tick();
        check("bp_full_rdy", rdy_a, 0);
        check("bp_full_out", out_a, 32'hAAAA_0001);
        In1 = 32'hCCCC_0003;
        tick();
        check("bp_c_cnt", cnt_a, 2);
        check("bp_c_rdy", rdy_a, 0);
        check("bp_hold_out", out_a, 32'hAAAA_0001);
        InValid  = 1'b0;
        OutReady = 1'b1;
        tick();
        check("bp_pop1_out", out_a, 32'hBBBB_0002);
        check("bp_pop1_rdy", rdy_a, 1);
        check("bp_pop1_ov", ov_a, 1);
        tick();
        check("bp_pop2_ov", ov_a, 0);
        check("bp_pop2_out", out_a, 32'hBBBB_0002);

        // 5: ten back-to-back ops with accept+pop
        do_reset();
        InValid = 1'b1;
        Op      = 3'b111;
        for (int i = 0; i < 10; i++) begin
            In1 = 32'h0101_0000 + 32'(i);
            tick();
            check($sformatf("b2b%0d_out", i), out_a, 32'h0101_0000 + 32'(i));
            check($sformatf("b2b%0d_ov", i), ov_a, 1);
            check($sformatf("b2b%0d_rdy", i), rdy_a, 1);
        end
        check("b2b_cnt", cnt_a, 10);
        InValid = 1'b0;
        tick();

        // 6: saturation on the CNT_W=2 instance, then reset while full
        do_reset();
        InValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat%0d_b", i), cnt_b, (i < 3) ? i + 1 : 3);
            check($sformatf("sat%0d_a", i), cnt_a, i + 1);
        end
        OutReady = 1'b0;
        tick();
        check("sat_full_rdy", rdy_b, 0);
        check("sat_full_ov", ov_b, 1);
        check("sat_full_cnt", cnt_b, 3);
        Rst_n = 1'b0;
        tick();
        check("rf_ov", ov_b, 0);
        check("rf_rdy", rdy_b, 0);
        check("rf_cnt", cnt_b, 0);
        check("rf_out", out_b, 0);
        Rst_n   = 1'b1;
        InValid = 1'b0;
        tick();
        check("rf_rel_rdy", rdy_b, 1);
        check("rf_rel_ov", ov_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
